des_round_engine: RTL and testbench
===================================

DES_ROUND_ENGINE -- requirements
Module: des_round_engine

Interface
REQ-001 The block SHALL have parameter ROUNDS_PER_CYCLE, default 1, giving the Feistel rounds evaluated per clock; legal values are 1, 2, 4, 8 and 16, and any other value SHALL cause an elaboration error.
REQ-002 clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  in_data, in_key and in_decrypt are valid.
REQ-005 in_ready  output  1  the engine can accept a block.
REQ-006 in_data  input  [1:64]  plaintext or ciphertext; bit 1 is the MSB (FIPS 46-3 numbering).
REQ-007 in_key  input  [1:64]  DES key including parity bits; the parity bits SHALL be ignored.
REQ-008 in_decrypt  input  1  1 = decrypt (apply K16..K1); 0 = encrypt (apply K1..K16).
REQ-009 out_valid  output  1  out_data holds a completed result.
REQ-010 out_ready  input  1  the consumer accepts out_data.
REQ-011 out_data  output  [1:64]  result after the final permutation FP.

Function
REQ-012 States SHALL be IDLE, RUN and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-013 In IDLE, when in_valid is 1, the engine SHALL register IP(in_data) as L0/R0, register PC1(in_key) as C0/D0, latch in_decrypt, clear the round counter and enter RUN.
REQ-014 In RUN, each cycle SHALL apply ROUNDS_PER_CYCLE rounds: L' = R, R' = L xor f(R, Ki), with f = P(S(E(R) xor Ki)) and Ki = PC2(Ci, Di).
REQ-015 Encrypt SHALL derive each subkey by left-rotating C and D using the schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 and applying PC2 after rotation.
REQ-016 Decrypt SHALL use K16 = PC2(C0,D0) first, then right-rotate by the reversed schedule (0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1) before each subsequent round.
REQ-017 The round counter SHALL advance by ROUNDS_PER_CYCLE per RUN cycle; after round 16 the engine SHALL enter DONE and load out_data = FP(R16 || L16), the final swap.
REQ-018 Latency: out_valid SHALL rise exactly 16/ROUNDS_PER_CYCLE cycles after the accepting edge.
REQ-019 In DONE, out_valid and out_data SHALL hold stable until out_ready is 1; on that edge the engine SHALL enter IDLE.
REQ-020 The engine SHALL NOT accept a new block on the same edge that out_ready drains DONE; the minimum issue interval is 16/ROUNDS_PER_CYCLE + 2 cycles.
REQ-021 While in RUN or DONE, in_valid, in_data, in_key and in_decrypt SHALL be ignored; changes to them SHALL NOT affect the block in flight.
REQ-022 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-023 While rst is 1, the engine SHALL be in IDLE with in_ready = 1, out_valid = 0, out_data = 0, the round counter = 0, and all data and key registers = 0.
REQ-024 Reset asserted during RUN or DONE SHALL abandon the block immediately; no out_valid SHALL follow for that block.

Configuration
REQ-025 With DES_ROUND_ENGINE_ZEROIZE_EN defined, the L, R, C and D registers and out_data SHALL be cleared to 0 on the edge that leaves DONE.
REQ-026 Without DES_ROUND_ENGINE_ZEROIZE_EN, those registers SHALL retain their last values until the next accept; externally visible handshake timing SHALL be identical in both builds.

Structure
REQ-027 Package des_pkg SHALL hold the IP, FP, E, P, PC1 and PC2 tables, the eight S-boxes, the rotation schedule and the state encoding.
REQ-028 The sub-module des_feistel_round SHALL hold one combinational round (f function plus swap); the engine SHALL instantiate it ROUNDS_PER_CYCLE times in a chain with per-stage key rotation.

Verification
REQ-029 Encrypt, ROUNDS_PER_CYCLE = 1: key 133457799BBCDFF1, data 0123456789ABCDEF -> out_data 85E813540F0AB405, with out_valid rising 16 cycles after accept.
REQ-030 Decrypt, same key, data 85E813540F0AB405 -> out_data 0123456789ABCDEF; repeat for ROUNDS_PER_CYCLE = 2, 4, 8 and 16 with latencies 8, 4, 2 and 1.
REQ-031 Key 0E329232EA6D0D73, data 8787878787878787, encrypt -> out_data 0000000000000000; hold out_ready = 0 for 5 cycles -> out_valid and out_data stay stable and in_ready stays 0.
REQ-032 Weak key 0101010101010101: encrypt 0123456789ABCDEF, then encrypt the result -> out_data 0123456789ABCDEF.
REQ-033 Assert rst at round 7, then release and send the REQ-029 vector -> no spurious out_valid; the correct result appears with nominal latency.
REQ-034 Toggle in_data and in_key every cycle during RUN -> result unchanged; for the zeroize build, check internal registers are 0 one cycle after the DONE drain.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg -- shared DES definitions for the round engine.
// Holds the FIPS 46-3 permutation tables (IP, FP, E, P, PC1, PC2), the eight
// S-boxes, the per-round C/D rotation schedules for both directions, the
// engine state encoding and small helper functions that apply the tables.
// All vectors use FIPS numbering: bit 1 is the MSB, so table entries index
// the [1:N] vectors directly.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // S-boxes flattened as box*64 + row*16 + col.
  localparam int SBOX [512] = '{
    // S1
    14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
     0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
     4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
    15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
    // S2
    15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
     3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
     0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
    13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
    // S3
    10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
    13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
    13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
     1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
    // S4
     7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
    13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
    10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
     3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
    // S5
     2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
    14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
     4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
    11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
    // S6
    12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
    10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
     9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
     4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
    // S7
     4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
    13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
     1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
     6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
    // S8
    13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
     1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
     7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
     2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11
  };

  // Left-rotation amounts applied before rounds 1..16 when encrypting.
  localparam int ROT_ENC [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  // Right-rotation amounts applied before rounds 1..16 when decrypting.
  // The leading 0 lets the first decrypt round use K16 = PC2(C0, D0).
  localparam int ROT_DEC [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [1:64] ip_perm(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 0; i < 64; i++) y[i+1] = x[IP_TAB[i]];
    return y;
  endfunction

  function automatic logic [1:64] fp_perm(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 0; i < 64; i++) y[i+1] = x[FP_TAB[i]];
    return y;
  endfunction

  function automatic logic [1:48] e_expand(input logic [1:32] x);
    logic [1:48] y;
    for (int i = 0; i < 48; i++) y[i+1] = x[E_TAB[i]];
    return y;
  endfunction

  function automatic logic [1:32] p_perm(input logic [1:32] x);
    logic [1:32] y;
    for (int i = 0; i < 32; i++) y[i+1] = x[P_TAB[i]];
    return y;
  endfunction

  function automatic logic [1:56] pc1_perm(input logic [1:64] x);
    logic [1:56] y;
    for (int i = 0; i < 56; i++) y[i+1] = x[PC1_TAB[i]];
    return y;
  endfunction

  function automatic logic [1:48] pc2_perm(input logic [1:56] x);
    logic [1:48] y;
    for (int i = 0; i < 48; i++) y[i+1] = x[PC2_TAB[i]];
    return y;
  endfunction

  // Eight 6-to-4 lookups; outer bits of each group select the row,
  // inner four bits select the column.
  function automatic logic [1:32] s_layer(input logic [1:48] x);
    logic [1:32] y;
    logic [5:0]  six;
    for (int b = 0; b < 8; b++) begin
      six = x[b*6+1 +: 6];
      y[b*4+1 +: 4] = 4'(SBOX[b*64 + int'({six[5], six[0], six[4:1]})]);
    end
    return y;
  endfunction

  function automatic logic [1:0] rot_amount(input logic decrypt, input logic [3:0] idx);
    return decrypt ? 2'(ROT_DEC[idx]) : 2'(ROT_ENC[idx]);
  endfunction

  function automatic logic [1:28] rotl28(input logic [1:28] x, input logic [1:0] amt);
    case (amt)
      2'd1:    return {x[2:28], x[1]};
      2'd2:    return {x[3:28], x[1:2]};
      default: return x;
    endcase
  endfunction

  function automatic logic [1:28] rotr28(input logic [1:28] x, input logic [1:0] amt);
    case (amt)
      2'd1:    return {x[28], x[1:27]};
      2'd2:    return {x[27:28], x[1:26]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_feistel_round.sv
// des_feistel_round -- one combinational DES round.
// Computes L' = R and R' = L xor P(S(E(R) xor K)).
// Ports:
//   l, r     in   [1:32]  round input halves
//   subkey   in   [1:48]  round key Ki
//   l_next   out  [1:32]  next left half
//   r_next   out  [1:32]  next right half
module des_feistel_round
  import des_pkg::*;
(
  input  logic [1:32] l,
  input  logic [1:32] r,
  input  logic [1:48] subkey,
  output logic [1:32] l_next,
  output logic [1:32] r_next
);

  logic [1:48] mixed;
  logic [1:32] f_out;

  assign mixed  = e_expand(r) ^ subkey;
  assign f_out  = p_perm(s_layer(mixed));
  assign l_next = r;
  assign r_next = l ^ f_out;

endmodule

// File: rtl/des_round_engine.sv
// des_round_engine -- iterative DES encrypt/decrypt engine.
// Evaluates ROUNDS_PER_CYCLE Feistel rounds per clock (1, 2, 4, 8 or 16),
// giving a latency of 16/ROUNDS_PER_CYCLE cycles from accept to out_valid.
// Handshake: a block is taken on a rising edge with in_valid && in_ready;
// a result leaves on a rising edge with out_valid && out_ready. in_ready is
// high only in IDLE and out_valid only in DONE, so the engine holds one block
// at a time and never accepts on the edge that drains a result.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_data  [1:64]     plaintext or ciphertext (bit 1 = MSB)
//   in_key   [1:64]     key with parity bits (parity ignored)
//   in_decrypt          1 = decrypt, 0 = encrypt
//   out_valid/out_ready output handshake
//   out_data [1:64]     result after FP
// Build option: DES_ROUND_ENGINE_ZEROIZE_EN clears L, R, C, D and out_data
// on the edge that leaves DONE; handshake timing is the same either way.
module des_round_engine
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:64] in_data,
  input  logic [1:64] in_key,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:64] out_data
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_param
    $error("des_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_t      state_q, state_d;
  logic [1:32] l_q, r_q;
  logic [1:28] c_q, d_q;
  logic [4:0]  cnt_q;
  logic        decrypt_q;
  logic        last_step;

  // Key parity bits take no part in the cipher.
  logic unused_parity;
  assign unused_parity = ^{in_key[8], in_key[16], in_key[24], in_key[32],
                           in_key[40], in_key[48], in_key[56], in_key[64]};

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign last_step = ((cnt_q + 5'(ROUNDS_PER_CYCLE)) == 5'd16);

  // Round chain: stage k works on absolute round cnt_q + k. Each stage
  // rotates C/D by that round's schedule entry, then derives its subkey.
  logic [1:32] l_st [0:ROUNDS_PER_CYCLE];
  logic [1:32] r_st [0:ROUNDS_PER_CYCLE];
  logic [1:28] c_st [0:ROUNDS_PER_CYCLE];
  logic [1:28] d_st [0:ROUNDS_PER_CYCLE];

  assign l_st[0] = l_q;
  assign r_st[0] = r_q;
  assign c_st[0] = c_q;
  assign d_st[0] = d_q;

  for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
    logic [3:0]  rnd;
    logic [1:0]  amt;
    logic [1:28] c_rot, d_rot;
    logic [1:48] subkey;

    assign rnd    = cnt_q[3:0] + 4'(k);
    assign amt    = rot_amount(decrypt_q, rnd);
    assign c_rot  = decrypt_q ? rotr28(c_st[k], amt) : rotl28(c_st[k], amt);
    assign d_rot  = decrypt_q ? rotr28(d_st[k], amt) : rotl28(d_st[k], amt);
    assign subkey = pc2_perm({c_rot, d_rot});
    assign c_st[k+1] = c_rot;
    assign d_st[k+1] = d_rot;

    des_feistel_round u_round (
      .l      (l_st[k]),
      .r      (r_st[k]),
      .subkey (subkey),
      .l_next (l_st[k+1]),
      .r_next (r_st[k+1])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      decrypt_q <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            {l_q, r_q} <= ip_perm(in_data);
            {c_q, d_q} <= pc1_perm(in_key);
            decrypt_q  <= in_decrypt;
            cnt_q      <= '0;
          end
        end
        RUN: begin
          l_q   <= l_st[ROUNDS_PER_CYCLE];
          r_q   <= r_st[ROUNDS_PER_CYCLE];
          c_q   <= c_st[ROUNDS_PER_CYCLE];
          d_q   <= d_st[ROUNDS_PER_CYCLE];
          cnt_q <= cnt_q + 5'(ROUNDS_PER_CYCLE);
          // Final swap: output block is R16 || L16 before FP.
          if (last_step) begin
            out_data <= fp_perm({r_st[ROUNDS_PER_CYCLE], l_st[ROUNDS_PER_CYCLE]});
          end
        end
        DONE: begin
`ifdef DES_ROUND_ENGINE_ZEROIZE_EN
          if (out_ready) begin
            l_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            out_data <= '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
// tb_des_round_engine -- directed bench for des_round_engine.
// Five engines (ROUNDS_PER_CYCLE = 1, 2, 4, 8, 16) share every input and are
// driven in lock-step; each one's latency and result are checked against
// known-answer DES vectors.
module tb_des_round_engine;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:64] in_data;
  logic [1:64] in_key;
  logic        in_decrypt;
  logic        out_ready;
  logic        in_ready_v  [N];
  logic        out_valid_v [N];
  logic [1:64] out_data_v  [N];

  int          total = 0;
  int          bad   = 0;
  int          lat   [N];
  logic [63:0] res   [N];
  logic [63:0] exp_q [$];
  logic        toggle_en;
  logic [63:0] weak_mid;
  int          spurious;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    des_round_engine #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready_v[g]),
      .in_data    (in_data),
      .in_key     (in_key),
      .in_decrypt (in_decrypt),
      .out_valid  (out_valid_v[g]),
      .out_ready  (out_ready),
      .out_data   (out_data_v[g])
    );
  end

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] data, input logic [63:0] key, input logic dec);
    in_data    = data;
    in_key     = key;
    in_decrypt = dec;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
  endtask

  // Watch 20 cycles after the accepting edge, recording each engine's
  // first out_valid cycle and data. out_ready stays low throughout.
  task automatic collect();
    for (int g = 0; g < N; g++) begin
      lat[g] = -1;
      res[g] = '0;
    end
    for (int c = 1; c <= 20; c++) begin
      if (toggle_en) begin
        in_data    = {$urandom, $urandom};
        in_key     = {$urandom, $urandom};
        in_decrypt = 1'($urandom_range(0, 1));
        in_valid   = 1'($urandom_range(0, 1));
      end
      tick();
      for (int g = 0; g < N; g++) begin
        if (out_valid_v[g] === 1'b1 && lat[g] < 0) begin
          lat[g] = c;
          res[g] = out_data_v[g];
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_lat(input string tag);
    for (int g = 0; g < N; g++)
      chk64($sformatf("%s_lat_r%0d", tag, 1 << g), 64'(lat[g]), 64'(16 >> g));
  endtask

  task automatic check_results(input string tag);
    logic [63:0] exp;
    exp = exp_q.pop_front();
    check_lat(tag);
    for (int g = 0; g < N; g++)
      chk64($sformatf("%s_data_r%0d", tag, 1 << g), res[g], exp);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int g = 0; g < N; g++) begin
      chk64($sformatf("%s_drain_ready_r%0d", tag, 1 << g), 64'(in_ready_v[g]), 64'd1);
      chk64($sformatf("%s_drain_valid_r%0d", tag, 1 << g), 64'(out_valid_v[g]), 64'd0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_key     = '0;
    in_decrypt = 1'b0;
    out_ready  = 1'b0;
    toggle_en  = 1'b0;
    tick();
    tick();

    // Reset state
    for (int g = 0; g < N; g++) begin
      chk64($sformatf("rst_ready_r%0d", 1 << g), 64'(in_ready_v[g]), 64'd1);
      chk64($sformatf("rst_valid_r%0d", 1 << g), 64'(out_valid_v[g]), 64'd0);
      chk64($sformatf("rst_data_r%0d", 1 << g), out_data_v[g], 64'd0);
    end
    chk64("rst_cnt", 64'(g_dut[0].u_dut.cnt_q), 64'd0);
    chk64("rst_lr", {g_dut[0].u_dut.l_q, g_dut[0].u_dut.r_q}, 64'd0);
    chk64("rst_cd", 64'({g_dut[0].u_dut.c_q, g_dut[0].u_dut.d_q}), 64'd0);
    rst = 1'b0;
    tick();

    // out_ready while idle does nothing
    out_ready = 1'b1;
    tick();
    tick();
    chk64("idle_oready_valid", 64'(out_valid_v[0]), 64'd0);
    chk64("idle_oready_ready", 64'(in_ready_v[0]), 64'd1);
    out_ready = 1'b0;

    // Known-answer encrypt
    exp_q.push_back(64'h85E813540F0AB405);
    send(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0);
    chk64("enc_busy", 64'(in_ready_v[0]), 64'd0);
    collect();
    check_results("enc");
    drain("enc");

    // Known-answer decrypt
    exp_q.push_back(64'h0123456789ABCDEF);
    send(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1);
    collect();
    check_results("dec");
    drain("dec");

    // All-zero result, then stall the consumer for 5 cycles
    exp_q.push_back(64'h0000000000000000);
    send(64'h8787878787878787, 64'h0E329232EA6D0D73, 1'b0);
    collect();
    check_results("zero");
    for (int c = 0; c < 5; c++) begin
      tick();
      chk64($sformatf("stall_valid_%0d", c), 64'(out_valid_v[0]), 64'd1);
      chk64($sformatf("stall_data_%0d", c), out_data_v[0], 64'd0);
      chk64($sformatf("stall_ready_%0d", c), 64'(in_ready_v[0]), 64'd0);
    end
    drain("zero");

    // Weak key: encrypting twice returns the plaintext
    send(64'h0123456789ABCDEF, 64'h0101010101010101, 1'b0);
    collect();
    check_lat("weak1");
    weak_mid = res[0];
    drain("weak1");
    exp_q.push_back(64'h0123456789ABCDEF);
    send(weak_mid, 64'h0101010101010101, 1'b0);
    collect();
    check_results("weak2");
    drain("weak2");

    // Reset at round 7 abandons the block
    send(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0);
    for (int c = 0; c < 7; c++) tick();
    chk64("abort_cnt", 64'(g_dut[0].u_dut.cnt_q), 64'd7);
    rst = 1'b1;
    #1;
    for (int g = 0; g < N; g++) begin
      chk64($sformatf("abort_ready_r%0d", 1 << g), 64'(in_ready_v[g]), 64'd1);
      chk64($sformatf("abort_valid_r%0d", 1 << g), 64'(out_valid_v[g]), 64'd0);
    end
    chk64("abort_data", out_data_v[0], 64'd0);
    tick();
    rst = 1'b0;
    spurious = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int g = 0; g < N; g++)
        if (out_valid_v[g] !== 1'b0) spurious++;
    end
    chk64("abort_no_valid", 64'(spurious), 64'd0);
    exp_q.push_back(64'h85E813540F0AB405);
    send(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0);
    collect();
    check_results("after_abort");
    drain("after_abort");

    // Inputs toggling while busy do not disturb the block in flight
    exp_q.push_back(64'h85E813540F0AB405);
    send(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0);
    toggle_en = 1'b1;
    collect();
    toggle_en = 1'b0;
    check_results("toggle");

    // Drain with in_valid high: no accept on the draining edge
    in_data    = 64'h85E813540F0AB405;
    in_key     = 64'h133457799BBCDFF1;
    in_decrypt = 1'b1;
    in_valid   = 1'b1;
    drain("no_accept");
`ifdef DES_ROUND_ENGINE_ZEROIZE_EN
    chk64("zeroize_lr", {g_dut[0].u_dut.l_q, g_dut[0].u_dut.r_q}, 64'd0);
    chk64("zeroize_cd", 64'({g_dut[0].u_dut.c_q, g_dut[0].u_dut.d_q}), 64'd0);
    chk64("zeroize_out", out_data_v[0], 64'd0);
`endif
    // in_valid still high: accepted on the following edge
    tick();
    in_valid = 1'b0;
    chk64("late_accept_busy", 64'(in_ready_v[0]), 64'd0);
    exp_q.push_back(64'h0123456789ABCDEF);
    collect();
    check_results("late_accept");
    drain("late_accept");

    chk64("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
